norm_shift_ctrl: RTL and testbench
==================================

# norm_shift_ctrl

Normalization controller sitting directly upstream of `Barrel_Shifter` in the FPU datapath. It accepts the raw post-add mantissa (with carry-out) and its exponent, then locates the leading one and computes the shift direction, amount and injected bit. It drives the shifter's load/control inputs for the required number of cycles and signals completion when `N_mant_o` is valid, along with the adjusted exponent and zero/underflow/overflow flags.

## Interface
- `SWR`, 26, shifter data width: implicit bit + significand + guard + round.
- `EWR`, 5, shift-amount width; must satisfy 2^EWR > SWR.
- `EXPW`, 8, exponent width.
- `SHIFT_LAT`, 1, cycles from first `load_o` to valid `N_mant_o`; legal range 1..4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request; sampled only when `busy_o`=0.
- `data_i`  in  SWR+1  mantissa; bit SWR is the adder carry-out.
- `exp_i`  in  EXPW  biased exponent of `data_i`.
- `busy_o`  out  1  high from the accepted start until `done_o`, inclusive.
- `load_o`  out  1  to shifter `load_i`.
- `Shift_Value_o`  out  EWR  to shifter `Shift_Value_i`.
- `Left_Right_o`  out  1  to shifter; 1 = left, 0 = right.
- `Bit_Shift_o`  out  1  to shifter `Bit_Shift_i`; the injected bit.
- `shift_data_o`  out  SWR  to shifter `Shift_Data_i`; `data_i[SWR-1:0]` registered.
- `done_o`  out  1  one-cycle pulse; shifter output is valid.
- `exp_o`  out  EXPW  adjusted exponent; valid while `done_o`=1 and held until the next start.
- `zero_o`, `underflow_o`, `overflow_o`  out  1 each  status, same validity as `exp_o`.

## Operation
- FSM states: IDLE, DET, LOAD, DONE.
- IDLE: `start_i`=1 registers `data_i`/`exp_i` and moves to DET.
- DET: priority-encode the registered data and register the control fields, then move to LOAD.
  - Carry set: right shift by 1, `Bit_Shift_o`=1, `exp_o`=`exp_i`+1; if `exp_i`=2^EXPW−2, `overflow_o`=1 and `exp_o`=all-ones.
  - Else, with lz = leading zeros of bits [SWR-1:0] (0..SWR-1): left shift by lz, `Bit_Shift_o`=0, `exp_o`=`exp_i`−lz.
  - If `exp_i` ≤ lz: `underflow_o`=1, shift clamped to `exp_i`−1 (0 if `exp_i`=0), `exp_o`=0.
  - Data all zero: `zero_o`=1, shift 0, left, `exp_o`=0.
- LOAD: `load_o`=1 for SHIFT_LAT consecutive cycles, counted by a down-counter of width $clog2(SHIFT_LAT+1); control outputs and `shift_data_o` stay stable. Then move to DONE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `start_i` while busy is ignored, with no queuing.
- `start_i` in the DONE cycle is ignored; a new request is accepted no earlier than the following IDLE cycle.

## Timing
- Accepted start at edge N: DET in cycle N+1, `load_o` high in cycles N+2..N+1+SHIFT_LAT, `done_o` in cycle N+2+SHIFT_LAT.
- Total latency is SHIFT_LAT+2 cycles, plus 1 with `NORM_CTRL_PIPE_EN`.
- Back-to-back throughput is one request per SHIFT_LAT+3 cycles.
- Reset (`rst`=0, asynchronous) returns the FSM to IDLE and drives every output to 0. This includes `Left_Right_o`, `Shift_Value_o`, `shift_data_o`, `exp_o` and all flags.
- Reset mid-operation aborts the request: no `done_o`, and `load_o` drops immediately.

## Configuration
- `NORM_CTRL_PIPE_EN` defined:
  - Adds a state DET2 between DET and LOAD.
  - The lz result is registered in DET and the exponent adjust, clamp and flags are computed in DET2, for timing closure at large SWR.
  - Latency becomes SHIFT_LAT+3.
- Undefined: single DET state, behaviour as above.
- Externally visible results are identical either way; only cycle counts differ.

## Structure
- A shared package `norm_pkg` holds:
  - the state enum `norm_state_t`;
  - `LEFT`=1 and `RIGHT`=0 constants;
  - a function `lzc(data, width)`.
- One sub-module: `lead_zero_enc` (SWR → EWR count plus all-zero flag), purely combinational and reused by the rounding stage.

## Test plan
All scenarios use SWR=26, SHIFT_LAT=1.
1. Carry case: `data_i`=27'h4000000, `exp_i`=8'h80 → right, shift 1, `Bit_Shift_o`=1, `exp_o`=8'h81, `done_o` 3 cycles after start.
2. Leading zeros: `data_i`=27'h0800000, `exp_i`=8'h80 → left, shift 2, `exp_o`=8'h7E, `underflow_o`=0.
3. Zero data: `data_i`=0 → `zero_o`=1, shift 0, `exp_o`=0. Already normalized: `data_i`=27'h2000000 → shift 0, exponent unchanged.
4. Underflow: `data_i`=27'h0000001, `exp_i`=8'h05 → `underflow_o`=1, shift 4, `exp_o`=0. Overflow: carry with `exp_i`=8'hFE → `overflow_o`=1, `exp_o`=8'hFF.
5. Busy and reset: `start_i` held high during busy → exactly one `done_o` per SHIFT_LAT+3 cycles. `rst` low during LOAD → all outputs 0 immediately, no `done_o`.
6. SHIFT_LAT=3, with and without `NORM_CTRL_PIPE_EN` → `load_o` high exactly 3 cycles, `done_o` at 5 and 6 cycles after start respectively.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and helpers for the FPU normalization controller and rounding stage.
package norm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DET  = 3'd1,
    ST_DET2 = 3'd2,
    ST_LOAD = 3'd3,
    ST_DONE = 3'd4
  } norm_state_t;

  localparam logic LEFT  = 1'b1;
  localparam logic RIGHT = 1'b0;

  typedef struct packed {
    logic zero;
    logic underflow;
    logic overflow;
  } norm_flags_t;

  // Leading zeros of data[width-1:0]; returns width when that field is all zero.
  function automatic int unsigned lzc(input logic [63:0] data, input int unsigned width);
    int unsigned cnt;
    logic        found;
    cnt   = 0;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if ((i < int'(width)) && !found) begin
        if (data[i]) found = 1'b1;
        else         cnt++;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lead_zero_enc.sv
// Combinational leading-zero encoder: SWR-bit field to EWR-bit count plus all-zero flag.
module lead_zero_enc
  import norm_pkg::*;
#(
  parameter int unsigned SWR = 26,
  parameter int unsigned EWR = 5
) (
  input  logic [SWR-1:0] data,
  output logic [EWR-1:0] count_c,
  output logic           zero_c
);

  assign count_c = EWR'(lzc(64'(data), SWR));
  assign zero_c  = (data == '0);

endmodule

// File: rtl/norm_shift_ctrl.sv
// Normalization controller driving Barrel_Shifter load/control for SHIFT_LAT cycles.
// Optional NORM_CTRL_PIPE_EN adds a DET2 stage splitting lz detection from exponent adjust.
module norm_shift_ctrl
  import norm_pkg::*;
#(
  parameter int unsigned SWR       = 26,
  parameter int unsigned EWR       = 5,
  parameter int unsigned EXPW      = 8,
  parameter int unsigned SHIFT_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [SWR:0]    data_i,
  input  logic [EXPW-1:0] exp_i,
  output logic            busy_o,
  output logic            load_o,
  output logic [EWR-1:0]  Shift_Value_o,
  output logic            Left_Right_o,
  output logic            Bit_Shift_o,
  output logic [SWR-1:0]  shift_data_o,
  output logic            done_o,
  output logic [EXPW-1:0] exp_o,
  output logic            zero_o,
  output logic            underflow_o,
  output logic            overflow_o
);

  localparam int unsigned CNT_W = $clog2(SHIFT_LAT + 1);
  localparam int unsigned CW    = ((EXPW > EWR) ? EXPW : EWR) + 1;
  localparam logic [EXPW-1:0] EXP_OVF = ~EXPW'(1);

  norm_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_d, done_d, busy_d;

  logic             carry_q;
  logic [EXPW-1:0]  exp_q;
  logic [EWR-1:0]   lz_c, lz_s;
  logic             all_zero_c, zero_s;
  logic             commit_c;
  logic [CW-1:0]    exp_w_c, lz_w_c;

  logic [EWR-1:0]   shamt_c;
  logic             dir_c;
  logic             inject_c;
  logic [EXPW-1:0]  exp_adj_c;
  norm_flags_t      flags_c;

  lead_zero_enc #(.SWR(SWR), .EWR(EWR)) u_lze (
    .data    (shift_data_o),
    .count_c (lz_c),
    .zero_c  (all_zero_c)
  );

`ifdef NORM_CTRL_PIPE_EN
  logic [EWR-1:0] lz_q;
  logic           zero_q;

  // Register the encoder result so the exponent math starts from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lz_q   <= '0;
      zero_q <= 1'b0;
    end else if (state_q == ST_DET) begin
      lz_q   <= lz_c;
      zero_q <= all_zero_c;
    end
  end

  assign lz_s     = lz_q;
  assign zero_s   = zero_q;
  assign commit_c = (state_q == ST_DET2);
`else
  assign lz_s     = lz_c;
  assign zero_s   = all_zero_c;
  assign commit_c = (state_q == ST_DET);
`endif

  assign exp_w_c = CW'(exp_q);
  assign lz_w_c  = CW'(lz_s);

  // Shift direction/amount, injected bit, adjusted exponent and flags.
  always_comb begin
    shamt_c   = '0;
    dir_c     = LEFT;
    inject_c  = 1'b0;
    exp_adj_c = '0;
    flags_c   = '0;
    if (carry_q) begin
      dir_c    = RIGHT;
      shamt_c  = EWR'(1);
      inject_c = 1'b1;
      if (exp_q == EXP_OVF) begin
        flags_c.overflow = 1'b1;
        exp_adj_c        = '1;
      end else begin
        exp_adj_c = exp_q + EXPW'(1);
      end
    end else if (zero_s) begin
      flags_c.zero = 1'b1;
    end else if (exp_w_c <= lz_w_c) begin
      flags_c.underflow = 1'b1;
      shamt_c = (exp_q == '0) ? '0 : EWR'(exp_w_c - CW'(1));
    end else begin
      shamt_c   = lz_s;
      exp_adj_c = EXPW'(exp_w_c - lz_w_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_o  <= 1'b0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_o  <= load_d;
      done_o  <= done_d;
      busy_o  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_DET;
      ST_DET: begin
`ifdef NORM_CTRL_PIPE_EN
        state_d = ST_DET2;
`else
        state_d = ST_LOAD;
`endif
        cnt_d = CNT_W'(SHIFT_LAT);
      end
      ST_DET2: begin
        state_d = ST_LOAD;
        cnt_d   = CNT_W'(SHIFT_LAT);
      end
      ST_LOAD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    load_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // Operand capture on accept; control fields frozen from commit until the next request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_data_o  <= '0;
      carry_q       <= 1'b0;
      exp_q         <= '0;
      Shift_Value_o <= '0;
      Left_Right_o  <= 1'b0;
      Bit_Shift_o   <= 1'b0;
      exp_o         <= '0;
      zero_o        <= 1'b0;
      underflow_o   <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start_i) begin
        shift_data_o <= data_i[SWR-1:0];
        carry_q      <= data_i[SWR];
        exp_q        <= exp_i;
      end
      if (commit_c) begin
        Shift_Value_o <= shamt_c;
        Left_Right_o  <= dir_c;
        Bit_Shift_o   <= inject_c;
        exp_o         <= exp_adj_c;
        zero_o        <= flags_c.zero;
        underflow_o   <= flags_c.underflow;
        overflow_o    <= flags_c.overflow;
      end
    end
  end

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Self-checking bench for norm_shift_ctrl (SHIFT_LAT=1 and SHIFT_LAT=3 instances).
module tb_norm_shift_ctrl;

`ifdef NORM_CTRL_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic       dir;
    logic [4:0] sh;
    logic       bs;
    logic [7:0] e;
    logic       z;
    logic       uf;
    logic       ov;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [26:0] data_a = '0, data_b = '0;
  logic [7:0]  exp_a = '0, exp_b = '0;

  logic        busy_a, load_a, lr_a, bs_a, done_a, z_a, uf_a, ov_a;
  logic [4:0]  sv_a;
  logic [25:0] sd_a;
  logic [7:0]  expo_a;
  logic        busy_b, load_b, lr_b, bs_b, done_b, z_b, uf_b, ov_b;
  logic [4:0]  sv_b;
  logic [25:0] sd_b;
  logic [7:0]  expo_b;

  int n_tests = 0;
  int n_fail  = 0;
  int dn[$];

  always #5 clk = ~clk;

  norm_shift_ctrl #(.SWR(26), .EWR(5), .EXPW(8), .SHIFT_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .data_i(data_a), .exp_i(exp_a),
    .busy_o(busy_a), .load_o(load_a), .Shift_Value_o(sv_a), .Left_Right_o(lr_a),
    .Bit_Shift_o(bs_a), .shift_data_o(sd_a), .done_o(done_a), .exp_o(expo_a),
    .zero_o(z_a), .underflow_o(uf_a), .overflow_o(ov_a)
  );

  norm_shift_ctrl #(.SWR(26), .EWR(5), .EXPW(8), .SHIFT_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .data_i(data_b), .exp_i(exp_b),
    .busy_o(busy_b), .load_o(load_b), .Shift_Value_o(sv_b), .Left_Right_o(lr_b),
    .Bit_Shift_o(bs_b), .shift_data_o(sd_b), .done_o(done_b), .exp_o(expo_b),
    .zero_o(z_b), .underflow_o(uf_b), .overflow_o(ov_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic res_t mk(input logic dir, input logic [4:0] sh, input logic bs,
                              input logic [7:0] e, input logic z, input logic uf, input logic ov);
    res_t r;
    r.dir = dir; r.sh = sh; r.bs = bs; r.e = e; r.z = z; r.uf = uf; r.ov = ov;
    return r;
  endfunction

  // Reference: normalize so the top significand bit is the leading one.
  function automatic res_t ref_norm(input logic [26:0] d, input logic [7:0] e);
    res_t r;
    int   msb;
    int   lz;
    r = mk(1'b1, 5'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    if (d[26]) begin
      r.dir = 1'b0; r.sh = 5'd1; r.bs = 1'b1;
      if (e == 8'hFE) begin r.ov = 1'b1; r.e = 8'hFF; end
      else r.e = e + 8'd1;
    end else if (d == 27'd0) begin
      r.z = 1'b1;
    end else begin
      msb = -1;
      for (int i = 0; i < 26; i++) if (d[i]) msb = i;
      lz = 25 - msb;
      if (int'(e) <= lz) begin
        r.uf = 1'b1;
        r.sh = (e == 8'd0) ? 5'd0 : 5'(int'(e) - 1);
      end else begin
        r.sh = 5'(lz);
        r.e  = 8'(int'(e) - lz);
      end
    end
    return r;
  endfunction

  task automatic run_a(input logic [26:0] d, input logic [7:0] e, input res_t r, input string tag);
    int cyc;
    int loads;
    @(negedge clk);
    start_a = 1'b1; data_a = d; exp_a = e;
    @(negedge clk);
    start_a = 1'b0; data_a = 27'($urandom); exp_a = 8'($urandom);
    cyc = 1; loads = 0;
    while (done_a !== 1'b1 && cyc < 40) begin
      if (load_a === 1'b1) loads++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(LAT_A + 2 + PIPE));
    chk({tag, ".loads"}, 64'(loads), 64'(LAT_A));
    chk({tag, ".busy_at_done"}, 64'(busy_a), 64'(1));
    chk({tag, ".dir"}, 64'(lr_a), 64'(r.dir));
    chk({tag, ".shift"}, 64'(sv_a), 64'(r.sh));
    chk({tag, ".bitshift"}, 64'(bs_a), 64'(r.bs));
    chk({tag, ".shdata"}, 64'(sd_a), 64'(d[25:0]));
    chk({tag, ".exp"}, 64'(expo_a), 64'(r.e));
    chk({tag, ".flags"}, 64'({z_a, uf_a, ov_a}), 64'({r.z, r.uf, r.ov}));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done_a), 64'(0));
    chk({tag, ".busy_after"}, 64'(busy_a), 64'(0));
    chk({tag, ".exp_held"}, 64'(expo_a), 64'(r.e));
  endtask

  task automatic run_b(input logic [26:0] d, input logic [7:0] e, input string tag);
    int   cyc;
    int   loads;
    res_t r;
    r = ref_norm(d, e);
    @(negedge clk);
    start_b = 1'b1; data_b = d; exp_b = e;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1; loads = 0;
    while (done_b !== 1'b1 && cyc < 40) begin
      if (load_b === 1'b1) loads++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(LAT_B + 2 + PIPE));
    chk({tag, ".loads"}, 64'(loads), 64'(LAT_B));
    chk({tag, ".ctrl"}, 64'({lr_b, sv_b, bs_b}), 64'({r.dir, r.sh, r.bs}));
    chk({tag, ".exp"}, 64'(expo_b), 64'(r.e));
    chk({tag, ".flags"}, 64'({z_b, uf_b, ov_b}), 64'({r.z, r.uf, r.ov}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [26:0] d;
    logic [7:0]  e;
    logic [31:0] rv;
    int          cyc;
    int          ndone;
    int          period;

    repeat (2) @(negedge clk);
    chk("reset.outs_a", 64'({busy_a, load_a, sv_a, lr_a, bs_a, sd_a, done_a, expo_a, z_a, uf_a, ov_a}), 64'(0));
    chk("reset.outs_b", 64'({busy_b, load_b, done_b, lr_b, expo_b}), 64'(0));
    rst = 1'b1;

    // Directed cases
    run_a(27'h4000000, 8'h80, mk(1'b0, 5'd1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0), "carry");
    run_a(27'h0800000, 8'h80, mk(1'b1, 5'd2, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0), "lz2");
    run_a(27'h0000000, 8'h80, mk(1'b1, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0), "zero");
    run_a(27'h2000000, 8'h80, mk(1'b1, 5'd0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0), "normed");
    run_a(27'h0000001, 8'h05, mk(1'b1, 5'd4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0), "underflow");
    run_a(27'h4000000, 8'hFE, mk(1'b0, 5'd1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1), "overflow");
    run_a(27'h0000100, 8'h00, mk(1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0), "uf_exp0");

    // Randomized cases against the reference model
    for (int k = 0; k < 40; k++) begin
      rv = $urandom;
      d  = 27'(rv >> $urandom_range(5, 32));
      e  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      if ($urandom_range(0, 9) == 0) e = 8'hFE;
      run_a(d, e, ref_norm(d, e), "rnd");
    end

    // start_i held high: one done per request period, no queuing
    period = LAT_A + 3 + PIPE;
    @(negedge clk);
    start_a = 1'b1; data_a = 27'h0800000; exp_a = 8'h80;
    for (int i = 0; i < 3 * period; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) dn.push_back(i);
    end
    start_a = 1'b0;
    chk("busy.done_count", 64'(dn.size()), 64'(3));
    if (dn.size() >= 3) begin
      chk("busy.spacing1", 64'(dn[1] - dn[0]), 64'(period));
      chk("busy.spacing2", 64'(dn[2] - dn[1]), 64'(period));
    end
    repeat (period) @(negedge clk);
    chk("busy.idle_after", 64'(busy_a), 64'(0));

    // Reset during LOAD aborts the request
    @(negedge clk);
    start_a = 1'b1; data_a = 27'h0000F00; exp_a = 8'h40;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (load_a !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst.load_seen", 64'(load_a), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("rst.outs_zero", 64'({busy_a, load_a, sv_a, lr_a, bs_a, sd_a, done_a, expo_a, z_a, uf_a, ov_a}), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) ndone++;
    end
    chk("rst.no_done", 64'(ndone), 64'(0));
    chk("rst.idle", 64'(busy_a), 64'(0));

    // SHIFT_LAT=3 instance
    run_b(27'h0800000, 8'h80, "lat3_lz");
    run_b(27'h4000000, 8'h10, "lat3_carry");
    for (int k = 0; k < 4; k++) begin
      rv = $urandom;
      run_b(27'(rv >> $urandom_range(5, 20)), 8'($urandom), "lat3_rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
